// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle for uart_tx_arbiter.
// Requesters drive valid/data/last and the arbiter answers with ready.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between
// N_REQ requesters, with packet lock and lock inactivity timeout.
module uart_tx_arbiter #(
    parameter int          N_REQ        = 4,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd65535,
    localparam int         GW           = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              resetn,
    uart_tx_arbiter_if.slave  req,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    output logic [GW-1:0]     grant_id,
    output logic              locked,
    output logic              timeout_pulse
);
    typedef enum logic [1:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    rr_q, rr_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0] ready_q, ready_d;
    logic             en_q, en_d;
    logic [7:0]       data_q, data_d;
    logic             locked_q, locked_d;
    logic             tp_q, tp_d;

    logic             win_vld;
    logic [GW-1:0]    win_idx;
    logic [GW-1:0]    cand;
    int               idx;
    logic             owner_vld;
    logic             arb_go;

    function automatic logic [GW-1:0] nxt(input logic [GW-1:0] g);
        if (int'(g) == N_REQ - 1) return '0;
        return g + 1'b1;
    endfunction

    assign owner_vld = req.req_valid[grant_q];
    assign arb_go    = (state_q == IDLE) && !uart_tx_busy && win_vld;

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        if (locked_q) begin
            win_vld = owner_vld;
            win_idx = grant_q;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_q) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                cand = GW'(idx);
                if (req.req_valid[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= '0;
            en_q     <= 1'b0;
            data_q   <= 8'h00;
            locked_q <= 1'b0;
            tp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            en_q     <= en_d;
            data_q   <= data_d;
            locked_q <= locked_d;
            tp_q     <= tp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (arb_go) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (uart_tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!uart_tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d  = '0;
        en_d     = 1'b0;
        data_d   = data_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        rr_d     = rr_q;
        tp_d     = 1'b0;
        cnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    ready_d[win_idx] = 1'b1;
                    en_d             = 1'b1;
                    data_d           = req.req_data[{win_idx, 3'b000} +: 8];
                    grant_d          = win_idx;
                end
                // Owner silent while holding the lock: count toward break.
                if (locked_q && !owner_vld) begin
                    if (cnt_q == LOCK_TIMEOUT) begin
                        locked_d = 1'b0;
                        rr_d     = nxt(grant_q);
                        tp_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ISSUE: begin
                if (req.req_last[grant_q]) begin
                    locked_d = 1'b0;
                    rr_d     = nxt(grant_q);
                end else begin
                    locked_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req.req_ready   = ready_q;
    assign uart_tx_en      = en_q;
    assign uart_tx_data    = data_q;
    assign grant_id        = grant_q;
    assign locked          = locked_q;
    assign timeout_pulse   = tp_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed
// corner sequences and randomized packets against a packet-level model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int LT = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       busy = 1'b0;
    logic       en;
    logic [7:0] txd;
    logic [1:0] gid;
    logic       lk;
    logic       tp;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(16'(LT))) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req           (bus),
        .uart_tx_en    (en),
        .uart_tx_data  (txd),
        .uart_tx_busy  (busy),
        .grant_id      (gid),
        .locked        (lk),
        .timeout_pulse (tp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = -1;
    int busy_left = 0;
    int frame_min = 3;
    int frame_max = 3;
    bit busy_auto = 1'b1;
    logic prev_en = 1'b0;
    logic [N-1:0] prev_ready = '0;

    logic [7:0] qd [N][$];
    logic       ql [N][$];
    int         log_g [$];
    logic [7:0] log_d [$];

    typedef struct {
        logic [3:0] mask;
        int         exp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = qd[i].size() > 0;
            bus.req_data[8*i +: 8] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
            bus.req_last[i] = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        qd[i].push_back(d);
        ql[i].push_back(l);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (qd[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        logic [31:0] head;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (prev_ready[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        if (!resetn) begin
            busy = 1'b0;
        end else if (busy_auto) begin
            if (prev_en) begin
                busy = 1'b1;
                busy_left = $urandom_range(frame_max, frame_min);
            end else if (busy) begin
                busy_left--;
                if (busy_left <= 0) begin
                    busy = 1'b0;
                    fall_cyc = cyc;
                end
            end
        end
        drive();
        if (en) begin
            log_g.push_back(int'(gid));
            log_d.push_back(txd);
            chk("ready_onehot", 32'(bus.req_ready), 32'(1) << gid);
            head = (qd[gid].size() > 0) ? 32'(qd[gid][0]) : 32'hFFFF_FFFF;
            chk("issue_data", 32'(txd), head);
            chk("issue_while_busy", {30'd0, prev_en, busy}, 32'd0);
        end else begin
            chk("stray_ready", 32'(bus.req_ready), 32'd0);
        end
        prev_en = en;
        prev_ready = bus.req_ready;
    endtask

    task automatic do_reset(input bit clr, input int n);
        resetn = 1'b0;
        if (clr) clear_q();
        drive();
        for (int k = 0; k < n; k++) step();
        resetn = 1'b1;
        busy = 1'b0;
        busy_left = 0;
        prev_en = 1'b0;
        prev_ready = '0;
        log_g.delete();
        log_d.delete();
    endtask

    task automatic wait_en(input string nm, input int lim, output int at);
        at = -1;
        for (int k = 0; k < lim; k++) begin
            step();
            if (en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) bound_fail(nm);
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int quiet;
        quiet = 0;
        for (int k = 0; k < lim; k++) begin
            step();
            if (all_empty() && !busy && !en) quiet++;
            else quiet = 0;
            if (quiet >= 3) return;
        end
        bound_fail(nm);
    endtask

    logic [7:0] md [N][$];
    logic       ml [N][$];
    int         eg [$];
    logic [7:0] ed [$];

    initial begin
        int at, c0, d0, ptr, w, np, len, nbad, n;
        logic [7:0] b;
        logic l;

        tbl[0] = '{4'b0100, 2};
        tbl[1] = '{4'b0011, 0};
        tbl[2] = '{4'b1001, 3};
        tbl[3] = '{4'b1110, 1};
        tbl[4] = '{4'b0001, 0};
        tbl[5] = '{4'b1111, 1};
        tbl[6] = '{4'b1011, 3};
        tbl[7] = '{4'b0110, 1};

        do_reset(1'b1, 3);
        chk("rst_en", 32'(en), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_data", 32'(txd), 0);
        chk("rst_grant", 32'(gid), 0);
        chk("rst_locked", 32'(lk), 0);
        chk("rst_timeout", 32'(tp), 0);

        // Pointer walks through the table from its reset value of 0.
        for (int e = 0; e < 8; e++) begin
            for (int i = 0; i < N; i++)
                if (tbl[e].mask[i]) push(i, 8'(16 * e + i), 1'b1);
            drive();
            c0 = cyc;
            wait_en("tbl_en", 10, at);
            chk("tbl_latency", 32'(at - c0), 1);
            chk("tbl_grant", 32'(gid), 32'(tbl[e].exp));
            chk("tbl_data", 32'(txd), 32'(16 * e + tbl[e].exp));
            for (int i = 0; i < N; i++)
                if (i != tbl[e].exp) begin
                    qd[i].delete();
                    ql[i].delete();
                end
            drive();
            wait_idle("tbl_idle", 60);
        end

        do_reset(1'b1, 1);
        push(2, 8'hA5, 1'b1);
        drive();
        c0 = cyc;
        wait_en("single_en", 10, at);
        chk("single_latency", 32'(at - c0), 1);
        chk("single_ready", 32'(bus.req_ready), 32'b0100);
        chk("single_data", 32'(txd), 32'hA5);
        step();
        chk("single_unlocked", 32'(lk), 0);
        wait_idle("single_idle", 60);
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        drive();
        wait_en("ptr3_en", 10, at);
        chk("single_ptr3", 32'(gid), 3);
        wait_idle("ptr3_idle", 80);

        do_reset(1'b1, 1);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
        drive();
        wait_en("rr_first", 10, at);
        for (int k = 1; k < 5; k++) begin
            wait_en("rr_en", 40, at);
            chk("rr_gap", 32'(at - fall_cyc), 2);
        end
        for (int k = 0; k < 5; k++)
            chk("rr_order", 32'(log_g[k]), 32'(k % N));
        wait_idle("rr_idle", 100);

        do_reset(1'b1, 1);
        push(1, 8'h1A, 1'b0);
        push(1, 8'h1B, 1'b0);
        push(1, 8'h1C, 1'b1);
        drive();
        wait_en("lock_en1", 10, at);
        chk("lock_g1", 32'(gid), 1);
        step();
        chk("lock_held", 32'(lk), 1);
        push(0, 8'h0F, 1'b1);
        drive();
        wait_en("lock_en2", 40, at);
        chk("lock_g2", 32'(gid), 1);
        wait_en("lock_en3", 40, at);
        chk("lock_g3", {gid, txd}, {2'd1, 8'h1C});
        step();
        chk("lock_release", 32'(lk), 0);
        wait_en("lock_en4", 40, at);
        chk("lock_next_owner", {gid, txd}, {2'd0, 8'h0F});
        wait_idle("lock_idle", 60);

        do_reset(1'b1, 1);
        push(3, 8'h3A, 1'b0);
        drive();
        wait_en("to_en", 10, at);
        push(0, 8'h0B, 1'b1);
        drive();
        c0 = 0;
        while (fall_cyc <= at && c0 < 50) begin
            step();
            c0++;
        end
        if (fall_cyc <= at) bound_fail("to_fall");
        d0 = fall_cyc;
        nbad = 0;
        while (cyc < d0 + 21) begin
            step();
            if (tp || en) nbad++;
        end
        chk("to_quiet", 32'(nbad), 0);
        chk("to_still_locked", 32'(lk), 1);
        step();
        chk("to_pulse", {tp, lk}, 2'b10);
        step();
        chk("to_grant", {en, tp, gid}, {1'b1, 1'b0, 2'd0});
        wait_idle("to_idle", 60);

        do_reset(1'b1, 1);
        push(1, 8'h51, 1'b0);
        push(1, 8'h52, 1'b1);
        drive();
        wait_en("mid_en", 10, at);
        c0 = 0;
        while (!busy && c0 < 10) begin
            step();
            c0++;
        end
        step();
        chk("mid_locked", 32'(lk), 1);
        do_reset(1'b0, 1);
        chk("mid_rst", {en, 4'(bus.req_ready), gid, lk, tp}, 32'd0);
        push(0, 8'h01, 1'b1);
        push(2, 8'h21, 1'b1);
        drive();
        wait_en("mid_en2", 10, at);
        chk("mid_grant0", 32'(gid), 0);
        wait_idle("mid_idle", 100);

        do_reset(1'b1, 1);
        busy_auto = 1'b0;
        busy = 1'b1;
        for (int i = 0; i < N; i++) push(i, 8'(8'hC0 + i), 1'b1);
        drive();
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (en || bus.req_ready != 0) n++;
        end
        chk("stall_quiet", 32'(n), 0);
        busy = 1'b0;
        busy_auto = 1'b1;
        c0 = cyc;
        wait_en("stall_en", 5, at);
        chk("stall_latency", 32'(at - c0), 1);
        chk("stall_grant", 32'(gid), 0);
        wait_idle("stall_idle", 200);

        frame_min = 1;
        frame_max = 6;
        for (int r = 0; r < 4; r++) begin
            do_reset(1'b1, 1);
            for (int i = 0; i < N; i++) begin
                md[i].delete();
                ml[i].delete();
                np = $urandom_range(4, 0);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(4, 1);
                    for (int q = 0; q < len; q++) begin
                        b = 8'($urandom);
                        push(i, b, q == len - 1);
                        md[i].push_back(b);
                        ml[i].push_back(q == len - 1);
                    end
                end
            end
            eg.delete();
            ed.delete();
            ptr = 0;
            while (1) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && md[(ptr + k) % N].size() > 0)
                        w = (ptr + k) % N;
                if (w < 0) break;
                do begin
                    b = md[w].pop_front();
                    l = ml[w].pop_front();
                    eg.push_back(w);
                    ed.push_back(b);
                end while (!l);
                ptr = (w + 1) % N;
            end
            drive();
            wait_idle("rnd_idle", 3000);
            chk("rnd_count", 32'(log_g.size()), 32'(eg.size()));
            n = (log_g.size() < eg.size()) ? log_g.size() : eg.size();
            for (int k = 0; k < n; k++)
                chk("rnd_issue", (log_g[k] << 8) | int'(log_d[k]),
                    (eg[k] << 8) | int'(ed[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single `uart_tx` byte transmitter between `N_REQ` independent byte-stream requesters. It accepts bytes over per-requester valid/ready handshakes and issues each byte to the transmitter as a one-cycle `uart_tx_en` pulse with data. It then tracks `uart_tx_busy` until the frame completes. Multi-byte packets are kept contiguous on the line by a packet lock, and an inactivity timeout breaks a stalled lock.

## Interface
- `N_REQ`, 4: number of requesters, legal range 2..8.
- `LOCK_TIMEOUT`, 16'd65535: idle cycles a locked owner may go without a valid byte before the lock is broken. Range 1..65535.
- `GW`, derived as $clog2(N_REQ): width of the grant index. Not overridable.
- `clk`  in  1  system clock, shared with `uart_tx`.
- `resetn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  per-requester byte valid. Must hold, with data and last stable, until `req_ready` is seen.
- `req_data`  in  8*N_REQ  requester i byte on bits [8i+7:8i].
- `req_last`  in  N_REQ  byte is the last of its packet. A 1 on a single-byte packet means no lock.
- `req_ready`  out  N_REQ  one-hot, one-cycle accept pulse.
- `uart_tx_en`  out  1  one-cycle send strobe to the transmitter.
- `uart_tx_data`  out  8  byte to the transmitter. Valid while `uart_tx_en`=1.
- `uart_tx_busy`  in  1  transmitter busy.
- `grant_id`  out  GW  index of the current or last owner.
- `locked`  out  1  packet lock held by `grant_id`.
- `timeout_pulse`  out  1  one-cycle pulse when a lock is broken by timeout.

## Operation
- All outputs are registered. Reset values:
  - `req_ready`=0, `uart_tx_en`=0, `uart_tx_data`=8'h00.
  - `grant_id`=0, `locked`=0, `timeout_pulse`=0.
  - Round-robin pointer=0, lock counter=0, state=IDLE.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Arbitrates only when `uart_tx_busy`=0.
  - If locked, only the owner `grant_id` is eligible.
  - If unlocked, the first requester with `req_valid`=1 is chosen, searching from the pointer upward with wrap.
  - On a winner, the state moves to ISSUE and `grant_id` is registered.
- **ISSUE** (exactly 1 cycle)
  - `uart_tx_en`=1, `uart_tx_data`=winner byte, `req_ready[winner]`=1.
  - Next state is WAIT_BUSY.
  - If `req_last`=1: `locked`←0 and pointer←winner+1 mod N_REQ.
  - If `req_last`=0: `locked`←1.
- **WAIT_BUSY**: stays until `uart_tx_busy`=1, then moves to WAIT_DONE.
- **WAIT_DONE**: stays until `uart_tx_busy`=0, then moves to IDLE.
- **Lock timeout** (evaluated in IDLE while `locked`=1)
  - A 16-bit counter increments each cycle that `req_valid[grant_id]`=0.
  - It clears on owner valid and on leaving IDLE.
  - When the counter equals `LOCK_TIMEOUT`: `locked`←0, pointer←`grant_id`+1 mod N_REQ, `timeout_pulse`=1 for one cycle, and the counter clears.
  - The same cycle performs no grant. Arbitration resumes on the next cycle.
- **Non-owner requests** while locked are held off. Their `req_ready` stays 0 and their data is untouched.
- **Simultaneous valids**: the pointer-order winner is taken. The others keep valid and are served in later rounds.
- **Reset mid-frame**: the arbiter returns to IDLE with lock cleared. The in-flight handshake is dropped. `uart_tx` shares `resetn`, so no stale frame completes.

## Timing
- **Grant latency**: valid sampled in IDLE at cycle T (UART idle, unlocked) gives `req_ready`/`uart_tx_en` high in cycle T+1.
- `uart_tx_busy` rises at T+2, one cycle after `uart_tx_en`.
- **Byte-to-byte**: busy low first seen in WAIT_DONE at cycle D gives IDLE at D+1 and the next ISSUE at D+2.
- `uart_tx_en` is never asserted while `uart_tx_busy`=1 and never on two consecutive cycles.
- **Bounded wait**: each requester is guaranteed a grant within N_REQ packets or timeouts of the others.

## Test plan
- **Single byte**:
  - Stimulus: requester 2 sends 8'hA5 with last=1, all other requesters idle.
  - Response: `req_ready`=4'b0100 and `uart_tx_en` one cycle after valid. The line carries A5 (start, LSB first, stop). `locked` stays 0. Pointer becomes 3.
- **Round robin**:
  - Stimulus: all 4 requesters continuously valid with last=1, bytes 8'h10+i.
  - Response: issue order 0,1,2,3,0. One frame per `uart_tx_busy` period. Exactly one IDLE cycle between busy fall and the next ISSUE.
- **Packet lock**:
  - Stimulus: requester 1 sends a 3-byte packet (last on byte 3) while requester 0 is valid throughout.
  - Response: bytes 1a,1b,1c are contiguous with `locked`=1 until the third ISSUE. Requester 0 is granted next.
- **Lock timeout**:
  - Stimulus: `LOCK_TIMEOUT`=20. Requester 3 sends one byte with last=0, then drops valid. Requester 0 is valid.
  - Response: `timeout_pulse` fires 20 idle cycles after entering IDLE. `locked`→0. Requester 0 is issued 2 cycles later.
- **Reset mid-frame**:
  - Stimulus: assert `resetn`=0 for 1 cycle during WAIT_DONE of a locked packet.
  - Response: all outputs are at reset values the next cycle. The next grant starts from requester 0.
- **Stall check**:
  - Stimulus: force `uart_tx_busy`=1 externally while requesters are valid.
  - Response: no `uart_tx_en` and no `req_ready` until busy drops.
